// File: rtl/serial_msb_comparator.sv
// Bit-serial unsigned magnitude comparator: scans operands MSB first, one bit pair per clock,
// and stops at the first differing pair. Result flags are held until the next accepted start.
module serial_msb_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             LT,
  output logic             GT,
  output logic             EQ
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             msb_a, msb_b;

  assign msb_a = sa_q[WIDTH-1];
  assign msb_b = sb_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(WIDTH);
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (msb_a && !msb_b) begin
          gt_d    = 1'b1;
          state_d = DONE;
        end else if (!msb_a && msb_b) begin
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CW'(1)) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          // Zero fill keeps exhausted positions equal, so they never decide the result.
          sa_d    = sa_q << 1;
          sb_d    = sb_q << 1;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign LT   = lt_q;
  assign GT   = gt_q;
  assign EQ   = eq_q;

endmodule

// File: tb/tb_serial_msb_comparator.sv
// Bench for serial_msb_comparator: WIDTH=8 and WIDTH=1 instances, scoreboard of expected results.
module tb_serial_msb_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy8, done8, lt8, gt8, eq8;
  logic       busy1, done1, lt1, gt1, eq1;
  bit         sel = 1'b0;

  logic obs_busy, obs_done, obs_lt, obs_gt, obs_eq;
  assign obs_busy = sel ? busy1 : busy8;
  assign obs_done = sel ? done1 : done8;
  assign obs_lt   = sel ? lt1   : lt8;
  assign obs_gt   = sel ? gt1   : gt8;
  assign obs_eq   = sel ? eq1   : eq8;

  serial_msb_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .LT(lt8), .GT(gt8), .EQ(eq8)
  );

  serial_msb_comparator #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .LT(lt1), .GT(gt1), .EQ(eq1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lt;
    logic gt;
    logic eq;
    int   lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t model(logic [7:0] x, logic [7:0] y, int w);
    exp_t e;
    bit   found = 1'b0;
    e.lt  = (x < y);
    e.gt  = (x > y);
    e.eq  = (x == y);
    e.lat = w;
    for (int i = w - 1; i >= 0; i--) begin
      if (!found && x[i] != y[i]) begin
        e.lat = w - i;
        found = 1'b1;
      end
    end
    return e;
  endfunction

  // Presents a one-cycle start; returns #1 after the accepting edge.
  task automatic drive_start(input logic [7:0] x, input logic [7:0] y, input bit push);
    @(negedge clk);
    if (sel) begin
      start1 = 1'b1; a1 = x[0]; b1 = y[0];
    end else begin
      start8 = 1'b1; a8 = x; b8 = y;
    end
    if (push) sb_q.push_back(model(x, y, sel ? 1 : 8));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc, output bit busy_at_done,
                           output bit to);
    lat = 0; busy_cyc = 0; busy_at_done = 1'b0; to = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (obs_done) begin
        lat = j; busy_at_done = obs_busy; to = 1'b0;
        break;
      end
      if (obs_busy) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({busy8, done8, lt8, gt8, eq8, busy1, done1, lt1, gt1, eq1} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000000000",
               {busy8, done8, lt8, gt8, eq8, busy1, done1, lt1, gt1, eq1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] ta[4] = '{8'h80, 8'h12, 8'hFF, 8'h00};
    logic [7:0] tb[4] = '{8'h7F, 8'h13, 8'h00, 8'h01};
    int lat, bc; bit bd, to; exp_t e;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_start(ta[i], tb[i], 1'b1);
      wait_done(lat, bc, bd, to);
      e = sb_q.pop_front();
      n_cmp++;
      if (to) begin n_err++; $display("FAIL basic_timeout[%0d]: no done within 40 cycles", i); end
      n_cmp++;
      if (lat !== e.lat) begin n_err++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++;
      if ({obs_lt, obs_gt, obs_eq} !== {e.lt, e.gt, e.eq}) begin
        n_err++; $display("FAIL basic_result[%0d]: got LGE=%b want %b", i, {obs_lt, obs_gt, obs_eq}, {e.lt, e.gt, e.eq});
      end
      n_cmp++;
      if (bc !== e.lat || bd !== 1'b0) begin
        n_err++; $display("FAIL basic_busy[%0d]: got %0d cycles (busy@done=%0b) want %0d (0)", i, bc, bd, e.lat);
      end
      @(negedge clk);
      n_cmp++;
      if (obs_done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse[%0d]: got %0b want 0", i, obs_done); end
    end
  endtask

  task automatic test_eq_hold;
    logic [7:0] v[2] = '{8'hA5, 8'h00};
    int lat, bc; bit bd, to, bad; exp_t e;
    sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_start(v[i], v[i], 1'b1);
      wait_done(lat, bc, bd, to);
      e = sb_q.pop_front();
      n_cmp++;
      if (to || lat !== e.lat || {obs_lt, obs_gt, obs_eq} !== {e.lt, e.gt, e.eq}) begin
        n_err++; $display("FAIL eq_result[%0d]: got lat=%0d LGE=%b to=%0b want lat=%0d LGE=%b",
                          i, lat, {obs_lt, obs_gt, obs_eq}, to, e.lat, {e.lt, e.gt, e.eq});
      end
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if ({obs_lt, obs_gt, obs_eq} !== 3'b001) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin n_err++; $display("FAIL eq_hold[%0d]: flags not held at LGE=001 over 5 idle cycles", i); end
      drive_start(8'hFF, 8'h00, 1'b1);
      n_cmp++;
      if ({obs_lt, obs_gt, obs_eq} !== 3'b000) begin
        n_err++; $display("FAIL eq_clear[%0d]: got LGE=%b want 000", i, {obs_lt, obs_gt, obs_eq});
      end
      wait_done(lat, bc, bd, to);
      e = sb_q.pop_front();
      n_cmp++;
      if (to || lat !== e.lat || {obs_lt, obs_gt, obs_eq} !== {e.lt, e.gt, e.eq}) begin
        n_err++; $display("FAIL eq_next[%0d]: got lat=%0d LGE=%b want lat=%0d LGE=%b",
                          i, lat, {obs_lt, obs_gt, obs_eq}, e.lat, {e.lt, e.gt, e.eq});
      end
    end
  endtask

  task automatic test_ignored_start;
    int lat; bit to, spurious; exp_t e;
    sel = 1'b0;
    drive_start(8'h10, 8'h20, 1'b1);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat = 1; to = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done8) begin to = 1'b0; break; end
      lat++;
    end
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (to || lat !== e.lat || {lt8, gt8, eq8} !== {e.lt, e.gt, e.eq}) begin
      n_err++; $display("FAIL ignored_result: got lat=%0d LGE=%b to=%0b want lat=%0d LGE=%b",
                        lat, {lt8, gt8, eq8}, to, e.lat, {e.lt, e.gt, e.eq});
    end
    spurious = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done8 || busy8 || {lt8, gt8, eq8} !== 3'b100) spurious = 1'b1;
    end
    n_cmp++;
    if (spurious) begin n_err++; $display("FAIL ignored_drop: extra activity seen, got busy=%0b done=%0b LGE=%b want 0 0 100",
                                          busy8, done8, {lt8, gt8, eq8}); end
  endtask

  task automatic test_back_to_back;
    int first, second, cnt; exp_t e0, e1;
    sel = 1'b0;
    first = -1; second = -1; cnt = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
    sb_q.push_back(model(8'h10, 8'h20, 8));
    sb_q.push_back(model(8'h10, 8'h20, 8));
    @(posedge clk);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done8) begin
        if (cnt == 0) first = j; else second = j;
        cnt++;
        if (cnt == 2) break;
      end
    end
    start8 = 1'b0;
    e0 = sb_q.pop_front();
    e1 = sb_q.pop_front();
    n_cmp++;
    if (first !== e0.lat) begin n_err++; $display("FAIL b2b_first: got %0d want %0d", first, e0.lat); end
    n_cmp++;
    if (second - first !== e1.lat + 2) begin
      n_err++; $display("FAIL b2b_interval: got %0d want %0d", second - first, e1.lat + 2);
    end
    n_cmp++;
    if ({lt8, gt8, eq8} !== {e1.lt, e1.gt, e1.eq}) begin
      n_err++; $display("FAIL b2b_result: got LGE=%b want %b", {lt8, gt8, eq8}, {e1.lt, e1.gt, e1.eq});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bc; bit bd, to, seen; exp_t e;
    sel = 1'b0;
    drive_start(8'h01, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy8, done8, lt8, gt8, eq8} !== 5'b0) begin
      n_err++; $display("FAIL reset_mid_outputs: got %b want 00000", {busy8, done8, lt8, gt8, eq8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL reset_mid_lost: got done/busy activity after reset want none"); end
    drive_start(8'h03, 8'h02, 1'b1);
    wait_done(lat, bc, bd, to);
    e = sb_q.pop_front();
    n_cmp++;
    if (to || lat !== e.lat || {lt8, gt8, eq8} !== {e.lt, e.gt, e.eq}) begin
      n_err++; $display("FAIL reset_mid_restart: got lat=%0d LGE=%b to=%0b want lat=%0d LGE=%b",
                        lat, {lt8, gt8, eq8}, to, e.lat, {e.lt, e.gt, e.eq});
    end
  endtask

  task automatic test_width1;
    int lat, bc; bit bd, to; exp_t e;
    logic [7:0] x, y;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = {7'd0, i[1]};
      y = {7'd0, i[0]};
      drive_start(x, y, 1'b1);
      wait_done(lat, bc, bd, to);
      e = sb_q.pop_front();
      n_cmp++;
      if (to || lat !== 1) begin n_err++; $display("FAIL w1_latency[%0d]: got %0d (to=%0b) want 1", i, lat, to); end
      n_cmp++;
      if ({lt1, gt1, eq1} !== {e.lt, e.gt, e.eq}) begin
        n_err++; $display("FAIL w1_result[%0d]: got LGE=%b want %b", i, {lt1, gt1, eq1}, {e.lt, e.gt, e.eq});
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eq_hold();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    n_cmp++;
    if (sb_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_msb_comparator.md
# serial_msb_comparator

- Bit-serial magnitude comparator for two unsigned WIDTH-bit operands.
- Captures both operands on a start handshake and scans them one bit per clock, MSB first. Stops at the first differing bit and reports LT/GT/EQ with a one-cycle done pulse.
- Scans in the direction opposite to the LSB-to-MSB ripple comparator cell. It is the low-area sequential alternative wherever a full-width combinational comparator chain is too large.

## Interface
- WIDTH, default 8: operand width in bits; legal range is WIDTH >= 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low. One clock, no other reset.
- start  input  1  request a comparison; it is accepted only in IDLE.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse; high only in DONE.
- LT  output  1  result A < B.
- GT  output  1  result A > B.
- EQ  output  1  result A == B.

## Operation
- States:
  - IDLE: waiting.
  - SCAN: comparing one bit pair per cycle.
  - DONE: result-report cycle.
- Internal state:
  - sa, sb: WIDTH-bit left-shift registers.
  - cnt: counts remaining bit pairs, sized to hold WIDTH.
- IDLE, start=1 on a rising edge:
  - sa<=a, sb<=b, cnt<=WIDTH.
  - LT, GT, EQ <= 0.
  - Go to SCAN.
- IDLE, start=0: hold everything.
- SCAN, each edge, looking at sa[WIDTH-1] and sb[WIDTH-1]:
  - sa MSB=1, sb MSB=0: GT<=1, go to DONE.
  - sa MSB=0, sb MSB=1: LT<=1, go to DONE.
  - Bits equal and cnt==1: EQ<=1, go to DONE.
  - Bits equal and cnt>1: shift sa and sb left by 1 (zero fill), cnt<=cnt-1, stay in SCAN.
- DONE: the next edge goes unconditionally to IDLE.
- start is ignored in SCAN and DONE; a request presented there is dropped, not queued.
- LT/GT/EQ behaviour:
  - At most one of them is ever high.
  - They are valid from entry to DONE and held through IDLE until the next start is accepted, which clears all three.
- Reset (rst_n=0, at any time including mid-SCAN):
  - Immediately: state=IDLE, busy=0, done=0, LT=GT=EQ=0, sa=sb=0, cnt=0.
  - Any in-flight comparison is lost.
- The first edge with rst_n=1 behaves as an IDLE edge, so start may be accepted on it.

## Timing
- Edge E0 accepts start. busy=1 from E0 until the edge that leaves SCAN.
- Let k be the 1-based position, counted from the MSB, of the first differing bit pair; k=WIDTH if the operands are equal.
- Results are registered at edge Ek.
  - done=1 and busy=0 in the cycle after Ek.
  - Edge E(k+1) returns to IDLE with done=0.
- Latency from the accepting edge to done high is k cycles: minimum 1, maximum WIDTH.
- Earliest next accept is E(k+2), because start must be sampled in IDLE. Throughput is at most one comparison per k+2 cycles.
- WIDTH=1: SCAN lasts exactly one edge; the comparison is always resolved at E1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=0x80, b=0x7F, start for one cycle:
  - busy high for exactly 1 cycle, then done=1 with GT=1, LT=0, EQ=0.
  - done rises 1 cycle after the accepting edge.
- a=0x12, b=0x13: LT=1 and done exactly 8 cycles after the accepting edge. a=0xFF, b=0x00: GT=1 after 1 cycle. a=0x00, b=0x01: LT=1 after 8 cycles.
- a=b=0xA5: EQ=1 after 8 cycles. a=b=0x00: EQ=1 after 8 cycles.
  - In both cases the result is held through at least 5 idle cycles.
  - The result clears to LT=GT=EQ=0 on the next accepting edge.
- Start with a=0x10, b=0x20, then change a/b and pulse start in SCAN and in the DONE cycle:
  - Both extra pulses are ignored.
  - The result is LT=1 after 3 cycles, reflecting only the sampled operands.
  - Holding start high continuously yields back-to-back comparisons every k+2 cycles.
- Reset mid-operation:
  - Start a=0x01, b=0x00 (k=8), then assert rst_n=0 asynchronously (off clock edge) in the 4th SCAN cycle.
  - All outputs go to 0 immediately, and no done pulse is ever produced.
  - After release, a new start with a=0x03, b=0x02 gives GT=1 after 8 cycles.
- WIDTH=1 instance, covering all four (a,b) pairs:
  - Each gives done 1 cycle after the accepting edge.
  - Results: (0,0) gives EQ, (0,1) gives LT, (1,0) gives GT, (1,1) gives EQ.
